// File: rtl/dostring_wavegen.sv
// Cosine-wave LED string frame generator for the doled SPI serializer.
// Each frame is a START word, NUM_LEDS tricolour LED words and an END word, then an idle gap.
module dostring_wavegen #(
    parameter int NUM_LEDS     = 47,
    parameter int TABLE_SIZE   = 60,
    parameter int MAX_COLOR    = 100,
    parameter int SPATIAL_STEP = 1,
    parameter int PHASE_STEP   = 1,
    parameter int FRAME_GAP    = 1000
) (
    input  logic        dostring_wavegen_clk,
    input  logic        dostring_wavegen_reset_n,
    input  logic        enable,
    input  logic        mirror,
    input  logic [7:0]  brightness,
    input  logic        doled_busy,
    output logic        led_start,
    output logic [1:0]  input_type,
    output logic [7:0]  red_out,
    output logic [7:0]  green_out,
    output logic [7:0]  blue_out,
    output logic        frame_done,
    output logic [15:0] frame_count
);
    localparam int IW = 8;
    localparam int LW = 8;
    localparam logic [IW-1:0] TS       = IW'(TABLE_SIZE);
    localparam logic [IW-1:0] SSTEP    = IW'(SPATIAL_STEP % TABLE_SIZE);
    localparam logic [IW-1:0] PSTEP    = IW'(PHASE_STEP % TABLE_SIZE);
    localparam logic [IW-1:0] G_OFF    = IW'(TABLE_SIZE / 3);
    localparam logic [IW-1:0] B_OFF    = IW'((2 * TABLE_SIZE) / 3);
    localparam logic [LW-1:0] LAST_LED = LW'(NUM_LEDS - 1);
    localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [GW-1:0] GAP_LAST = GW'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);
    localparam real PI = 3.14159265358979323846;

    typedef enum logic [2:0] {IDLE, START_W, LED_CALC, LED_W, END_W, GAP} state_t;
    typedef enum logic [1:0] {SEND_WAIT, SEND_STROBE, SEND_HOLD, SEND_DRAIN} send_t;

    state_t state, state_next;
    send_t  send_ph;
    logic            calc_step;
    logic [LW-1:0]   led, pos;
    logic [IW-1:0]   pos_acc, phase, r_idx, g_idx, b_idx;
    logic [7:0]      red_q, green_q, blue_q, bright_q;
    logic            mirror_q;
    logic [GW-1:0]   gap_cnt;
    logic            is_word, word_done;
    logic [LW-1:0]   next_led, next_pos;
    logic [IW-1:0]   base_idx;

    // Cosine table built at elaboration, rounded to nearest.
    logic [7:0] rom [TABLE_SIZE];
    for (genvar i = 0; i < TABLE_SIZE; i++) begin : g_rom
        localparam real ANGLE = 2.0 * PI * real'(i) / real'(TABLE_SIZE);
        localparam int  VALUE = $rtoi(real'(MAX_COLOR) * (1.0 + $cos(ANGLE)) / 2.0 + 0.5);
        assign rom[i] = 8'(VALUE);
    end

    function automatic logic [IW-1:0] mod_add(input logic [IW-1:0] a, input logic [IW-1:0] b);
        logic [IW:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, TS}) s = s - {1'b0, TS};
        return IW'(s);
    endfunction

    function automatic logic [IW-1:0] mod_sub(input logic [IW-1:0] a, input logic [IW-1:0] b);
        logic [IW:0] d;
        if (a >= b) d = {1'b0, a} - {1'b0, b};
        else        d = {1'b0, a} + {1'b0, TS} - {1'b0, b};
        return IW'(d);
    endfunction

    function automatic logic [7:0] scale(input logic [7:0] v, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, v} * ({8'd0, b} + 16'd1);
        return 8'(prod >> 8);
    endfunction

    assign is_word   = (state == START_W) || (state == LED_W) || (state == END_W);
    assign word_done = is_word && (send_ph == SEND_DRAIN) && !doled_busy;
    assign base_idx  = mod_add(phase, pos_acc);
    assign next_led  = led + LW'(1);
    assign next_pos  = (mirror_q && (next_led > LAST_LED - next_led)) ? LAST_LED - next_led : next_led;

    always_ff @(posedge dostring_wavegen_clk) begin
        if (!dostring_wavegen_reset_n) state <= IDLE;
        else                           state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:     if (enable) state_next = START_W;
            START_W:  if (word_done) state_next = LED_CALC;
            LED_CALC: if (calc_step) state_next = LED_W;
            LED_W:    if (word_done) state_next = (led == LAST_LED) ? END_W : LED_CALC;
            END_W: begin
                if (word_done) begin
                    if (FRAME_GAP == 0) state_next = enable ? START_W : IDLE;
                    else                state_next = GAP;
                end
            end
            GAP:      if (gap_cnt == GAP_LAST) state_next = enable ? START_W : IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        led_start  = is_word && (send_ph == SEND_STROBE);
        input_type = 2'd0;
        red_out    = 8'd0;
        green_out  = 8'd0;
        blue_out   = 8'd0;
        case (state)
            LED_W: begin
                input_type = 2'd1;
                red_out    = red_q;
                green_out  = green_q;
                blue_out   = blue_q;
            end
            END_W:   input_type = 2'd2;
            default: ;
        endcase
    end

    // Handshake sub-phases, per-LED index accumulators and frame bookkeeping.
    always_ff @(posedge dostring_wavegen_clk) begin
        if (!dostring_wavegen_reset_n) begin
            send_ph     <= SEND_WAIT;
            calc_step   <= 1'b0;
            led         <= '0;
            pos         <= '0;
            pos_acc     <= '0;
            phase       <= '0;
            r_idx       <= '0;
            g_idx       <= '0;
            b_idx       <= '0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            bright_q    <= '0;
            mirror_q    <= 1'b0;
            gap_cnt     <= '0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            frame_done <= 1'b0;
            if (is_word) begin
                unique case (send_ph)
                    SEND_WAIT:   if (!doled_busy) send_ph <= SEND_STROBE;
                    SEND_STROBE: send_ph <= SEND_HOLD;
                    SEND_HOLD:   send_ph <= SEND_DRAIN;
                    SEND_DRAIN:  if (!doled_busy) send_ph <= SEND_WAIT;
                    default:     send_ph <= SEND_WAIT;
                endcase
            end
            if (state == START_W && send_ph == SEND_STROBE) begin
                mirror_q <= mirror;
                bright_q <= brightness;
            end
            if (state == START_W && word_done) begin
                led     <= '0;
                pos     <= '0;
                pos_acc <= '0;
            end
            if (state == LED_CALC) begin
                calc_step <= ~calc_step;
                if (!calc_step) begin
                    r_idx <= base_idx;
                    g_idx <= mod_add(base_idx, G_OFF);
                    b_idx <= mod_add(base_idx, B_OFF);
                end else begin
                    red_q   <= scale(rom[r_idx], bright_q);
                    green_q <= scale(rom[g_idx], bright_q);
                    blue_q  <= scale(rom[b_idx], bright_q);
                end
            end
            // Mirror mode walks the position back down past the string centre.
            if (state == LED_W && word_done && led != LAST_LED) begin
                led <= next_led;
                pos <= next_pos;
                if (next_pos > pos)      pos_acc <= mod_add(pos_acc, SSTEP);
                else if (next_pos < pos) pos_acc <= mod_sub(pos_acc, SSTEP);
            end
            if (state == END_W && word_done) begin
                frame_done  <= 1'b1;
                frame_count <= frame_count + 16'd1;
                phase       <= mod_add(phase, PSTEP);
                gap_cnt     <= '0;
            end
            if (state == GAP) gap_cnt <= gap_cnt + GW'(1);
        end
    end
endmodule

// File: tb/tb_dostring_wavegen.sv
// Scoreboard bench for dostring_wavegen: a doled model consumes strobed words and
// compares each against a queue of words predicted from a cosine model.
`timescale 1ns/1ps
module tb_dostring_wavegen;
    localparam int  N        = 47;
    localparam int  TS       = 60;
    localparam int  GAP      = 20;
    localparam int  BUSY_LEN = 5;
    localparam real PI       = 3.14159265358979323846;

    typedef struct packed {
        logic [1:0] t;
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } word_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        mirror;
    logic [7:0]  brightness;
    logic        doled_busy;
    logic        led_start;
    logic [1:0]  input_type;
    logic [7:0]  red_out, green_out, blue_out;
    logic        frame_done;
    logic [15:0] frame_count;

    int    total = 0;
    int    bad = 0;
    word_t exp_q[$];
    int    rom_m[TS];
    int    rx_count = 0;
    int    done_count = 0;
    int    busy_cnt = 0;
    int    led_idx = 0;
    bit    force_busy = 1'b0;
    bit    prev_start = 1'b0;
    word_t last_word;
    word_t frame_leds[N];
    word_t f1_leds[N];
    int    m_phase = 0;
    int    m_count = 0;

    always #5 clk = ~clk;

    assign doled_busy = force_busy || (busy_cnt != 0);

    dostring_wavegen #(.FRAME_GAP(GAP)) dut (
        .dostring_wavegen_clk    (clk),
        .dostring_wavegen_reset_n(reset_n),
        .enable                  (enable),
        .mirror                  (mirror),
        .brightness              (brightness),
        .doled_busy              (doled_busy),
        .led_start               (led_start),
        .input_type              (input_type),
        .red_out                 (red_out),
        .green_out               (green_out),
        .blue_out                (blue_out),
        .frame_done              (frame_done),
        .frame_count             (frame_count)
    );

    // doled model: accepts strobes, stays busy for BUSY_LEN cycles, checks each word.
    always @(negedge clk) begin : monitor
        word_t got, want;
        if (led_start === 1'b1) begin
            got = {input_type, red_out, green_out, blue_out};
            rx_count++;
            last_word = got;
            if (got.t == 2'd0) led_idx = 0;
            else if (got.t == 2'd1 && led_idx < N) begin
                frame_leds[led_idx] = got;
                led_idx++;
            end
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("[TB] FAIL word_unexpected got t=%0d r=%0d g=%0d b=%0d want none",
                         got.t, got.r, got.g, got.b);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    bad++;
                    $display("[TB] FAIL word_%0d got t=%0d r=%0d g=%0d b=%0d want t=%0d r=%0d g=%0d b=%0d",
                             rx_count, got.t, got.r, got.g, got.b, want.t, want.r, want.g, want.b);
                end
            end
            busy_cnt = BUSY_LEN;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        if (prev_start && led_start === 1'b1) begin
            bad++;
            $display("[TB] FAIL strobe_consecutive got 1 want 0");
        end
        prev_start = (led_start === 1'b1);
        if (frame_done === 1'b1) done_count++;
    end

    function automatic word_t exp_led(input int ph, input int k, input bit mir, input int bri);
        int p, r, g, b;
        p = (mir && (N - 1 - k) < k) ? (N - 1 - k) : k;
        r = rom_m[(ph + p) % TS];
        g = rom_m[(ph + p + TS / 3) % TS];
        b = rom_m[(ph + p + (2 * TS) / 3) % TS];
        return {2'd1, 8'((r * (bri + 1)) / 256), 8'((g * (bri + 1)) / 256), 8'((b * (bri + 1)) / 256)};
    endfunction

    task automatic push_frame(input int ph, input bit mir, input int bri);
        exp_q.push_back({2'd0, 24'd0});
        for (int k = 0; k < N; k++) exp_q.push_back(exp_led(ph, k, mir, bri));
        exp_q.push_back({2'd2, 24'd0});
    endtask

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (done_count < target) begin
            bad++;
            $display("[TB] FAIL frame_done_timeout got %0d want %0d", done_count, target);
        end
    endtask

    task automatic wait_rx(input int target, input int budget);
        int n = 0;
        while (rx_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (rx_count < target) begin
            bad++;
            $display("[TB] FAIL word_timeout got %0d want %0d", rx_count, target);
        end
    endtask

    task automatic check_count();
        total++;
        if (frame_count !== 16'(m_count)) begin
            bad++;
            $display("[TB] FAIL frame_count got %0d want %0d", frame_count, m_count);
        end
    endtask

    task automatic check_idle(input int cycles);
        int s = rx_count;
        repeat (cycles) @(negedge clk);
        total++;
        if (rx_count != s || exp_q.size() != 0) begin
            bad++;
            $display("[TB] FAIL idle_words got %0d extra, %0d pending want 0, 0", rx_count - s, exp_q.size());
        end
    endtask

    task automatic run_frame(input bit mir, input int bri);
        int target = done_count + 1;
        mirror     = mir;
        brightness = 8'(bri);
        push_frame(m_phase, mir, bri);
        wait_done(target, 3000);
        m_count++;
        m_phase = (m_phase + 1) % TS;
        check_count();
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        enable     = 1'b0;
        mirror     = 1'b0;
        brightness = 8'd255;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (led_start !== 1'b0 || frame_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_strobes got %b%b want 00", led_start, frame_done);
        end
        total++;
        if ({input_type, red_out, green_out, blue_out} !== 26'd0) begin
            bad++;
            $display("[TB] FAIL reset_word got %h want 0", {input_type, red_out, green_out, blue_out});
        end
        check_count();
        reset_n = 1'b1;
        check_idle(30);
    endtask

    task automatic test_first_frame();
        enable = 1'b1;
        run_frame(1'b0, 255);
        total++;
        if (frame_leds[0] !== {2'd1, 8'd100, 8'd25, 8'd25}) begin
            bad++;
            $display("[TB] FAIL first_led0 got r=%0d g=%0d b=%0d want r=100 g=25 b=25",
                     frame_leds[0].r, frame_leds[0].g, frame_leds[0].b);
        end
        for (int k = 0; k < N; k++) f1_leds[k] = frame_leds[k];
    endtask

    task automatic test_phase_wrap();
        bit same;
        for (int i = 0; i < TS; i++) begin
            run_frame(1'b0, 255);
            if (i == 0) begin
                total++;
                if (frame_leds[0].r !== 8'd100 || frame_leds[1].r !== 8'd99) begin
                    bad++;
                    $display("[TB] FAIL phase1_red got %0d,%0d want 100,99", frame_leds[0].r, frame_leds[1].r);
                end
            end
        end
        same = 1'b1;
        for (int k = 0; k < N; k++) if (frame_leds[k] !== f1_leds[k]) same = 1'b0;
        total++;
        if (!same) begin
            bad++;
            $display("[TB] FAIL wrap_repeat got differing frame want identical to frame 1");
        end
    endtask

    task automatic test_mirror();
        bit sym = 1'b1;
        run_frame(1'b1, 255);
        for (int k = 0; k < N; k++) if (frame_leds[k] !== frame_leds[N - 1 - k]) sym = 1'b0;
        total++;
        if (!sym) begin
            bad++;
            $display("[TB] FAIL mirror_symmetry got asymmetric want symmetric");
        end
    endtask

    task automatic test_brightness();
        int target = done_count + 1;
        int base   = rx_count;
        int ph0    = m_phase;
        mirror     = 1'b0;
        brightness = 8'd127;
        push_frame(m_phase, 1'b0, 127);
        wait_rx(base + 2, 2000);
        brightness = 8'd10;
        wait_done(target, 3000);
        m_count++;
        m_phase = (m_phase + 1) % TS;
        check_count();
        total++;
        if (frame_leds[0].r !== 8'((rom_m[ph0] * 128) / 256)) begin
            bad++;
            $display("[TB] FAIL bright127_led0 got %0d want %0d", frame_leds[0].r, (rom_m[ph0] * 128) / 256);
        end
        run_frame(1'b0, 10);
    endtask

    task automatic test_busy_and_disable();
        int    target = done_count + 1;
        int    base   = rx_count;
        int    s0;
        word_t w0;
        bit    stable = 1'b1;
        mirror     = 1'b0;
        brightness = 8'd255;
        push_frame(m_phase, 1'b0, 255);
        wait_rx(base + 3, 2000);
        force_busy = 1'b1;
        s0 = rx_count;
        w0 = last_word;
        repeat (200) begin
            @(negedge clk);
            if ({input_type, red_out, green_out, blue_out} !== w0) stable = 1'b0;
        end
        total++;
        if (rx_count != s0) begin
            bad++;
            $display("[TB] FAIL stall_strobes got %0d want 0", rx_count - s0);
        end
        total++;
        if (!stable) begin
            bad++;
            $display("[TB] FAIL stall_stable got changed want held");
        end
        force_busy = 1'b0;
        wait_rx(base + 12, 2000);
        enable = 1'b0;
        wait_done(target, 3000);
        m_count++;
        m_phase = (m_phase + 1) % TS;
        check_count();
        check_idle(GAP * 5);
    endtask

    task automatic test_reset_midframe();
        int base;
        int target;
        mirror     = 1'b0;
        brightness = 8'd255;
        push_frame(m_phase, 1'b0, 255);
        base   = rx_count;
        enable = 1'b1;
        wait_rx(base + 5, 2000);
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        exp_q.delete();
        m_phase = 0;
        m_count = 0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        total++;
        if ({led_start, input_type, red_out, green_out, blue_out, frame_done} !== 28'd0) begin
            bad++;
            $display("[TB] FAIL midreset_outputs got %h want 0",
                     {led_start, input_type, red_out, green_out, blue_out, frame_done});
        end
        check_count();
        push_frame(0, 1'b0, 255);
        target = done_count + 1;
        wait_rx(rx_count + 1, 2000);
        enable = 1'b0;
        wait_done(target, 3000);
        m_count++;
        m_phase = (m_phase + 1) % TS;
        check_count();
        check_idle(GAP * 5);
    endtask

    initial begin
        for (int i = 0; i < TS; i++)
            rom_m[i] = int'($floor(100.0 * (1.0 + $cos(2.0 * PI * i / TS)) / 2.0 + 0.5));
        test_reset();
        test_first_frame();
        test_phase_wrap();
        test_mirror();
        test_brightness();
        test_busy_and_disable();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
